cla_pipe: RTL and testbench

CLA_PIPE -- requirements
Module: cla_pipe

---
 rtl/cla_pkg.sv | 13 +
 rtl/clg_cell.sv | 29 ++
 rtl/cla_pipe.sv | 188 ++++++++++++++++++
 tb/tb_cla_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Ports: none (package only).
// Provides CLA_GROUP (bits per lookahead group) and num_groups(width).
package cla_pkg;

    localparam int CLA_GROUP = 4;

    // Number of 4-bit lookahead groups needed to cover an operand of 'width' bits.
    function automatic int num_groups(input int width);
        return (width + CLA_GROUP - 1) / CLA_GROUP;
    endfunction

endpackage

// File: rtl/clg_cell.sv
// 4-input carry-lookahead cell: carries into each input position plus group G/P.
// Ports: g_i/p_i per-position generate/propagate, c_i carry in;
//        c_o carry into each position (c_o[0] = c_i), g_o/p_o group generate/propagate.
module clg_cell (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:0] c_o,
    output logic       g_o,
    output logic       p_o
);

    logic g_acc;

    always_comb begin
        c_o[0] = c_i;
        for (int k = 0; k < 3; k++) begin
            c_o[k+1] = g_i[k] | (p_i[k] & c_o[k]);
        end
        // Group generate: carry out of position 3 assuming zero carry in.
        g_acc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g_acc = g_i[k] | (p_i[k] & g_acc);
        end
        g_o = g_acc;
        p_o = &p_i;
    end

endmodule

// File: rtl/cla_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, c_in;
//        out_valid/out_ready with sum, c_out, g_out, p_out (and ovf when CLA_PIPE_OVERFLOW_EN is defined).
// Latency 2 cycles, one result per cycle; in_ready drops only when both stages are full and stalled.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             g_out,
`ifdef CLA_PIPE_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             p_out
);

    localparam int NG = num_groups(WIDTH);
    localparam int NB = (NG + CLA_GROUP - 1) / CLA_GROUP;

    // ---------------- Stage 1: bit and group generate/propagate ----------------
    logic [WIDTH-1:0] gen_bit, prop_bit, c0_bit;
    logic [NG-1:0]    grp_g, grp_p;

    assign gen_bit  = a & b;
    assign prop_bit = a ^ b;

    // c0_bit holds in-group carries assuming a zero carry into the group;
    // stage 2 adds the real group carry via the in-group propagate prefix.
    for (genvar k = 0; k < NG; k++) begin : g_l1
        clg_cell u_l1 (
            .g_i (gen_bit[CLA_GROUP*k +: CLA_GROUP]),
            .p_i (prop_bit[CLA_GROUP*k +: CLA_GROUP]),
            .c_i (1'b0),
            .c_o (c0_bit[CLA_GROUP*k +: CLA_GROUP]),
            .g_o (grp_g[k]),
            .p_o (grp_p[k])
        );
    end

    logic             s1_vld_q, s2_vld_q;
    logic [WIDTH-1:0] s1_p_q, s1_c0_q;
    logic [NG-1:0]    s1_gg_q, s1_gp_q;
    logic             s1_cin_q;

    logic s2_load, s1_adv, in_xfer;

    assign s2_load  = !s2_vld_q || out_ready;
    assign s1_adv   = s1_vld_q && s2_load;
    // Gated by rst_n so nothing is offered while reset is held.
    assign in_ready = rst_n && (!s1_vld_q || s1_adv);
    assign in_xfer  = in_valid && in_ready;

    // ---------------- Stage 2: second-level lookahead and sum ----------------
    // Unused tree inputs are padded with G=0, P=1 so they are transparent.
    logic [CLA_GROUP*NB-1:0] gg_ext, gp_ext, gc_ext;
    logic [NB-1:0]           blk_ci, blk_g, blk_p;
    logic                    tree_g, tree_p;

    always_comb begin
        gg_ext         = '0;
        gp_ext         = '1;
        gg_ext[NG-1:0] = s1_gg_q;
        gp_ext[NG-1:0] = s1_gp_q;
    end

    for (genvar j = 0; j < NB; j++) begin : g_l2
        clg_cell u_l2 (
            .g_i (gg_ext[CLA_GROUP*j +: CLA_GROUP]),
            .p_i (gp_ext[CLA_GROUP*j +: CLA_GROUP]),
            .c_i (blk_ci[j]),
            .c_o (gc_ext[CLA_GROUP*j +: CLA_GROUP]),
            .g_o (blk_g[j]),
            .p_o (blk_p[j])
        );
    end

    if (NB == 1) begin : g_tree1
        assign blk_ci = s1_cin_q;
        assign tree_g = blk_g[0];
        assign tree_p = blk_p[0];
    end else begin : g_tree2
        logic [3:0] top_g, top_p, top_c;
        always_comb begin
            top_g         = '0;
            top_p         = '1;
            top_g[NB-1:0] = blk_g;
            top_p[NB-1:0] = blk_p;
        end
        clg_cell u_top (
            .g_i (top_g),
            .p_i (top_p),
            .c_i (s1_cin_q),
            .c_o (top_c),
            .g_o (tree_g),
            .p_o (tree_p)
        );
        assign blk_ci = top_c[NB-1:0];
    end

    logic [WIDTH-1:0] carry;
    logic             pre;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             c_out_d, c_out_q, g_out_q, p_out_q;

    // Carry into bit j of group k = zero-carry-in carry | (propagate of bits below j) & group carry.
    always_comb begin
        carry = '0;
        pre   = 1'b1;
        for (int k = 0; k < NG; k++) begin
            pre = 1'b1;
            for (int j = 0; j < CLA_GROUP; j++) begin
                carry[CLA_GROUP*k+j] = s1_c0_q[CLA_GROUP*k+j] | (pre & gc_ext[k]);
                pre = pre & s1_p_q[CLA_GROUP*k+j];
            end
        end
        sum_d   = s1_p_q ^ carry;
        c_out_d = tree_g | (tree_p & s1_cin_q);
    end

`ifdef CLA_PIPE_OVERFLOW_EN
    logic ovf_d, ovf_q;
    assign ovf_d = c_out_d ^ carry[WIDTH-1];
    assign ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s1_adv) begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_p_q   <= '0;
            s1_c0_q  <= '0;
            s1_gg_q  <= '0;
            s1_gp_q  <= '0;
            s1_cin_q <= 1'b0;
            s2_vld_q <= 1'b0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            g_out_q  <= 1'b0;
            p_out_q  <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_vld_q <= 1'b1;
                s1_p_q   <= prop_bit;
                s1_c0_q  <= c0_bit;
                s1_gg_q  <= grp_g;
                s1_gp_q  <= grp_p;
                s1_cin_q <= c_in;
            end else if (s1_adv) begin
                s1_vld_q <= 1'b0;
            end
            if (s2_load) begin
                s2_vld_q <= s1_vld_q;
            end
            // Data only moves with a real result, so it holds under stall.
            if (s1_adv) begin
                sum_q   <= sum_d;
                c_out_q <= c_out_d;
                g_out_q <= tree_g;
                p_out_q <= tree_p;
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign g_out     = g_out_q;
    assign p_out     = p_out_q;

endmodule

// File: tb/tb_cla_pipe.sv
module tb_cla_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        g_out;
    logic        p_out;
    logic        ovf_w;

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .g_out     (g_out),
`ifdef CLA_PIPE_OVERFLOW_EN
        .ovf       (ovf_w),
`endif
        .p_out     (p_out)
    );

`ifndef CLA_PIPE_OVERFLOW_EN
    assign ovf_w = 1'b0;
`endif

    // Observed result packed as {sum, c_out, g_out, p_out, ovf}.
    logic [19:0] obs;
    assign obs = {sum, c_out, g_out, p_out, ovf_w};

    int n_checks = 0;
    int n_err    = 0;
    int cyc_n    = 0;
    bit lat_chk  = 1'b1;

    logic [19:0] exp_q[$];
    int          cyc_q[$];

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int full, gen, sx, sy, ss;
        logic ov;
        full = int'(x) + int'(y) + int'(ci);
        gen  = int'(x) + int'(y);
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        ss   = sx + sy + int'(ci);
`ifdef CLA_PIPE_OVERFLOW_EN
        ov = (ss > 32767) || (ss < -32768);
`else
        ov = 1'b0;
`endif
        return {full[15:0], full[16], gen[16], ((x ^ y) == 16'hFFFF), ov};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock cycle: drive at negedge, sample after settling, score transfers.
    task automatic cyc(input logic rst, input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic ordy);
        logic [19:0] e;
        int          t;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c_in      = ic;
        out_ready = ordy;
        #1;
        cyc_n++;
        if (out_valid === 1'b1 && out_ready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL spurious_out observed=%0h expected=none", obs);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = cyc_q.pop_front();
                check("result", 32'(obs), 32'(e));
                if (lat_chk) check("latency", cyc_n - t, 2);
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(model(ia, ib, ic));
            cyc_q.push_back(cyc_n);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [15:0] ra, rb;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;

        // Reset state
        cyc(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b1);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_data", 32'(obs), 0);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("post_rst_in_ready", in_ready, 1);

        // Boundary carry
        cyc(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("bnd_valid", out_valid, 1);
        check("bnd_result", 32'({sum, c_out, g_out, p_out}), 32'({16'h0000, 1'b1, 1'b1, 1'b0}));
        drain();

        // Full propagate
        cyc(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("prop_valid", out_valid, 1);
        check("prop_result", 32'({sum, c_out, g_out, p_out}), 32'({16'h0000, 1'b1, 1'b0, 1'b1}));
        drain();

        // Streaming back-to-back
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            cyc(1'b1, 1'b1, ra, rb, 1'($urandom), 1'b1);
            check("stream_in_ready", in_ready, 1);
        end
        drain();

        // Back-pressure: 3 offered with the consumer stalled
        lat_chk = 1'b0;
        cyc(1'b1, 1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
        check("bp_rdy1", in_ready, 1);
        cyc(1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0);
        check("bp_rdy2", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 16'h8000, 16'h8001, 1'b1, 1'b0);
            check("bp_stall_rdy", in_ready, 0);
            check("bp_stall_vld", out_valid, 1);
            check("bp_stall_hold", 32'(obs), 32'(exp_q[0]));
        end
        check("bp_accepted", exp_q.size(), 2);
        cyc(1'b1, 1'b1, 16'h8000, 16'h8001, 1'b1, 1'b1);
        check("bp_release_rdy", in_ready, 1);
        drain();

        // Random valid / ready mix
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            cyc(1'b1, 1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
        end
        drain();
        lat_chk = 1'b1;

        // Reset mid-stream with both stages full
        cyc(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("mid_full_rdy", in_ready, 0);
        cyc(1'b0, 1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0);
        check("mid_rst_rdy", in_ready, 0);
        exp_q.delete();
        cyc_q.delete();
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("mid_out_valid", out_valid, 0);
        check("mid_rdy_back", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            check("mid_no_stale", out_valid, 0);
        end

`ifdef CLA_PIPE_OVERFLOW_EN
        cyc(1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("ovf_pos", 32'({ovf_w, sum}), 32'({1'b1, 16'h8000}));
        cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("ovf_neg", 32'({ovf_w, c_out}), 32'({1'b1, 1'b1}));
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
